// File: rtl/bf_loader_if.sv
// Byte-stream bundle between the program source, the loader and the interpreter.
// The loader takes the master modport. The source and interpreter side takes the slave modport.
interface bf_loader_if;
  // Handshake rule for both byte streams: a byte moves only in a cycle where
  // valid and ack are both high. The ack side may look at valid in the same cycle.
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_last;
  logic       src_ack;
  logic       bf_in_valid;
  logic [7:0] bf_in_data;
  logic       bf_in_ack;
  logic       bf_start;
  logic       bf_ready;

  modport master (
    input  src_valid, src_data, src_last, bf_in_ack, bf_ready,
    output src_ack, bf_in_valid, bf_in_data, bf_start
  );

  modport slave (
    output src_valid, src_data, src_last, bf_in_ack, bf_ready,
    input  src_ack, bf_in_valid, bf_in_data, bf_start
  );
endinterface

// File: rtl/bf_loader.sv
// Front-end of the Brainfuck interpreter.
// It filters the program text down to command bytes and checks the program length
// and bracket balance. It writes the commands and a 0x00 terminator into code
// memory and pulses start. After that it forwards runtime input bytes until the
// interpreter reports ready again.
module bf_loader #(
  parameter int MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        nrst,
  bf_loader_if.master bus,
  output logic [7:0]  prog_len,
  output logic        busy,
  output logic        error,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TERM  = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] depth_q, depth_d;
  logic [7:0] len_q, len_d;
  logic       is_cmd;

  // Classify the current source byte as one of the eight commands or as a comment.
  always_comb begin
    is_cmd = 1'b0;
    case (bus.src_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
      default: is_cmd = 1'b0;
    endcase
  end

  // State, bracket depth and program length registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      depth_q <= 8'd0;
      len_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic and the combinational handshake outputs.
  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    len_d           = len_q;
    bus.src_ack     = 1'b0;
    bus.bf_in_valid = 1'b0;
    bus.bf_in_data  = 8'h00;
    bus.bf_start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The first byte is left in place. LOAD consumes it on the next cycle.
        if (bus.bf_ready && bus.src_valid) begin
          state_d = S_LOAD;
          depth_d = 8'd0;
          len_d   = 8'd0;
        end
      end
      S_LOAD: begin
        if (bus.src_valid) begin
          if (!is_cmd) begin
            // A comment byte is dropped in one cycle. It can still end the program.
            bus.src_ack = 1'b1;
            if (bus.src_last) state_d = (depth_q != 8'd0) ? S_ERR : S_TERM;
          end else if ((bus.src_data == 8'h5D && depth_q == 8'd0) || len_q == MAX_LEN_B) begin
            // A byte that would break the program is swallowed and not written.
            bus.src_ack = 1'b1;
            state_d     = S_ERR;
          end else begin
            bus.bf_in_valid = 1'b1;
            bus.bf_in_data  = bus.src_data;
            bus.src_ack     = bus.bf_in_ack;
            if (bus.bf_in_ack) begin
              len_d = len_q + 8'd1;
              if (bus.src_data == 8'h5B)      depth_d = depth_q + 8'd1;
              else if (bus.src_data == 8'h5D) depth_d = depth_q - 8'd1;
              if (bus.src_last) state_d = (depth_d != 8'd0) ? S_ERR : S_TERM;
            end
          end
        end
      end
      S_TERM: begin
        bus.bf_in_valid = 1'b1;
        if (bus.bf_in_ack) state_d = S_START;
      end
      S_START: begin
        // bf_in_valid stays low here so the start cycle never doubles as a code write.
        bus.bf_start = 1'b1;
        state_d      = S_RUN;
      end
      S_RUN: begin
        bus.bf_in_valid = bus.src_valid && !bus.bf_ready;
        bus.bf_in_data  = bus.src_data;
        bus.src_ack     = bus.bf_in_ack && !bus.bf_ready;
        if (bus.bf_ready) begin
          state_d = S_IDLE;
          depth_d = 8'd0;
        end
      end
      S_ERR: begin
        // This state holds until nrst. The interpreter's code pointer is not rewound.
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign prog_len    = len_q;
  assign busy        = (state_q != S_IDLE);
  assign error       = (state_q == S_ERR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bf_loader.sv
// Bench for bf_loader. Program texts are applied from a vector table, and a
// scoreboard checks every byte that reaches the interpreter. The bench models the
// interpreter's ack and ready behaviour.
module tb_bf_loader;

  logic       clk;
  logic       nrst;
  logic [7:0] prog_len;
  logic       busy;
  logic       error;
  logic [2:0] dbg_state;

  bf_loader_if bfi ();

  bf_loader #(.MAX_LEN(255)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bfi.master),
    .prog_len    (prog_len),
    .busy        (busy),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         start_cnt = 0;
  logic       end_req   = 1'b0;
  logic       ack_rand  = 1'b1;
  logic [7:0] prog_buf [300];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Interpreter model. It checks the bytes written to it, counts start pulses,
  // and drives bf_in_ack and bf_ready.
  initial begin
    logic st;
    bfi.bf_ready  = 1'b1;
    bfi.bf_in_ack = 1'b0;
    forever begin
      @(negedge clk);
      st = 1'b0;
      if (nrst) begin
        if (bfi.bf_in_valid && bfi.bf_in_ack) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL write_unexpected: got 0x%0h expected no write", bfi.bf_in_data);
          end else begin
            check("write_data", bfi.bf_in_data, exp_q.pop_front());
          end
        end
        if (bfi.bf_start) begin
          start_cnt++;
          check("start_without_valid", bfi.bf_in_valid, 0);
          st = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (st) bfi.bf_ready = 1'b0;
      else if (end_req) bfi.bf_ready = 1'b1;
      bfi.bf_in_ack = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bfi.src_valid = 1'b0;
    bfi.src_data  = 8'h00;
    bfi.src_last  = 1'b0;
    nrst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {bfi.src_ack, bfi.bf_in_valid, bfi.bf_in_data, bfi.bf_start, busy, error, prog_len}, 0);
    nrst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit got = 0;
    @(posedge clk);
    #1;
    bfi.src_valid = 1'b1;
    bfi.src_data  = b;
    bfi.src_last  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bfi.src_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL src_ack_timeout: got no ack for 0x%0h expected ack within 200 cycles", b);
    end
    @(posedge clk);
    #1;
    bfi.src_valid = 1'b0;
    bfi.src_last  = 1'b0;
  endtask

  // Sends prog_buf[0..n-1] with src_last on the final byte. Expected code writes are
  // queued from a reference model. Sending stops once the model sees a load error,
  // because the loader acks nothing after an error.
  task automatic load_text(input int n);
    int   depth = 0;
    int   len   = 0;
    bit   merr  = 0;
    logic [7:0] b;
    bit   last;
    bit   cmd;
    for (int i = 0; i < n; i++) begin
      if (merr) break;
      b    = prog_buf[i];
      last = (i == n - 1);
      cmd  = (b == 8'h2B || b == 8'h2D || b == 8'h3C || b == 8'h3E ||
              b == 8'h2E || b == 8'h2C || b == 8'h5B || b == 8'h5D);
      if (cmd) begin
        if ((b == 8'h5D && depth == 0) || len == 255) merr = 1;
        else begin
          exp_q.push_back(b);
          len++;
          if (b == 8'h5B) depth++;
          if (b == 8'h5D) depth--;
        end
      end
      if (last && !merr) begin
        if (depth != 0) merr = 1;
        else exp_q.push_back(8'h00);
      end
      send_byte(b, last);
    end
  endtask

  task automatic wait_done(input int s0);
    bit done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (error || start_cnt > s0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no start or error expected one within 100 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic end_run();
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    end_req = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] txt [8];
    int         n;
    logic       exp_err;
    logic [7:0] exp_len;
    int         exp_starts;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int s0;
    vecs[0].txt = '{8'h2B, 8'h5B, 8'h2D, 8'h5D, 8'h2E, 8'h00, 8'h00, 8'h00}; // "+[-]."
    vecs[0].n = 5; vecs[0].exp_err = 0; vecs[0].exp_len = 5; vecs[0].exp_starts = 1;
    vecs[1].txt = '{8'h61, 8'h2B, 8'h20, 8'h62, 8'h0A, 8'h3E, 8'h00, 8'h00}; // "a+ b\n>"
    vecs[1].n = 6; vecs[1].exp_err = 0; vecs[1].exp_len = 2; vecs[1].exp_starts = 1;
    vecs[2].txt = '{8'h5D, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; // "]+"
    vecs[2].n = 2; vecs[2].exp_err = 1; vecs[2].exp_len = 0; vecs[2].exp_starts = 0;
    vecs[3].txt = '{8'h5B, 8'h5B, 8'h2B, 8'h5D, 8'h00, 8'h00, 8'h00, 8'h00}; // "[[+]"
    vecs[3].n = 4; vecs[3].exp_err = 1; vecs[3].exp_len = 4; vecs[3].exp_starts = 0;
    vecs[4].txt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; // lone 0x00 comment
    vecs[4].n = 1; vecs[4].exp_err = 0; vecs[4].exp_len = 0; vecs[4].exp_starts = 1;

    nrst = 1'b0;
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) prog_buf[i] = vecs[v].txt[i];
      s0 = start_cnt;
      load_text(vecs[v].n);
      wait_done(s0);
      check($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      check($sformatf("v%0d_prog_len", v), prog_len, vecs[v].exp_len);
      check($sformatf("v%0d_starts", v), start_cnt - s0, vecs[v].exp_starts);
      check($sformatf("v%0d_all_written", v), exp_q.size(), 0);
      check($sformatf("v%0d_busy_held", v), busy, 1);
      if (!vecs[v].exp_err) begin
        end_run();
        check($sformatf("v%0d_idle_after_run", v), busy, 0);
      end
    end

    // A program of 256 commands: the 256th command overflows the length limit.
    do_reset();
    for (int i = 0; i < 256; i++) prog_buf[i] = 8'h2B;
    s0 = start_cnt;
    load_text(256);
    wait_done(s0);
    check("long_error", error, 1);
    check("long_prog_len", prog_len, 255);
    check("long_starts", start_cnt - s0, 0);
    check("long_all_written", exp_q.size(), 0);

    // ",." then one runtime byte in RUN, then return to IDLE.
    do_reset();
    prog_buf[0] = 8'h2C;
    prog_buf[1] = 8'h2E;
    s0 = start_cnt;
    load_text(2);
    wait_done(s0);
    check("run_starts", start_cnt - s0, 1);
    check("run_ready_low", bfi.bf_ready, 0);
    exp_q.push_back(8'h41);
    send_byte(8'h41, 1'b1);
    check("run_byte_written", exp_q.size(), 0);
    check("run_busy", busy, 1);
    end_run();
    check("run_back_idle", busy, 0);
    check("run_prog_len_held", prog_len, 2);
    check("run_no_error", error, 0);

    // Reset in the middle of a load discards it at once.
    prog_buf[0] = 8'h2B;
    prog_buf[1] = 8'h5B;
    exp_q.push_back(8'h2B);
    send_byte(8'h2B, 1'b0);
    exp_q.push_back(8'h5B);
    send_byte(8'h5B, 1'b0);
    check("midload_busy", busy, 1);
    check("midload_prog_len", prog_len, 2);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("midload_async_reset",
          {bfi.src_ack, bfi.bf_in_valid, bfi.bf_in_data, bfi.bf_start, busy, error, prog_len}, 0);
    check("midload_state_idle", dbg_state, 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
